// File: rtl/can_bit_tx.sv
// rtl/can_bit_tx.sv - CAN transmit bit engine: hold register, bit stuffing, readback checking.
// Optional CAN_TX_LOOPBACK_EN adds a loopback input that keeps tx recessive and compares internally.
module can_bit_tx #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_point,
  input  logic sample_point,
  input  logic sampled_bit,
  input  logic go_error_frame,
`ifdef CAN_TX_LOOPBACK_EN
  input  logic loopback,
`endif
  input  logic bit_valid,
  input  logic bit_data,
  input  logic bit_stuff_en,
  input  logic bit_arb,
  input  logic bit_last,
  output logic bit_ready,
  output logic tx,
  output logic tx_next,
  output logic transmitting,
  output logic tx_done,
  output logic arb_lost,
  output logic bit_err,
  output logic underrun_err
);

  typedef enum logic [1:0] {IDLE, SAMPLE, DRIVE} state_t;

  state_t     state, state_n;
  logic       hold_valid, hold_data, hold_stuff, hold_arb, hold_last;
  logic       hold_valid_n, hold_data_n, hold_stuff_n, hold_arb_n, hold_last_n;
  logic       cur_bit, cur_arb, cur_last;
  logic       cur_bit_n, cur_arb_n, cur_last_n;
  logic [2:0] run, run_n;
  logic       last_bit, last_bit_n;
  logic       stuff_pend, stuff_pend_n;
  logic       tx_n, done_n, arb_n, berr_n, under_n;
  logic       do_drive, go_idle, cmp_bit;

  assign bit_ready    = ~hold_valid;
  assign transmitting = (state != IDLE);
  assign tx_next      = stuff_pend ? ~last_bit : (hold_valid ? hold_data : 1'b1);

  always_comb begin
    state_n      = state;
    tx_n         = tx;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    hold_stuff_n = hold_stuff;
    hold_arb_n   = hold_arb;
    hold_last_n  = hold_last;
    cur_bit_n    = cur_bit;
    cur_arb_n    = cur_arb;
    cur_last_n   = cur_last;
    run_n        = run;
    last_bit_n   = last_bit;
    stuff_pend_n = stuff_pend;
    done_n       = 1'b0;
    arb_n        = 1'b0;
    berr_n       = 1'b0;
    under_n      = 1'b0;
    do_drive     = 1'b0;
    go_idle      = 1'b0;
    cmp_bit      = sampled_bit;
`ifdef CAN_TX_LOOPBACK_EN
    if (loopback) cmp_bit = cur_bit;
`endif

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_point && hold_valid) begin
          do_drive = 1'b1;
          state_n  = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sample_point) begin
          if (cmp_bit == cur_bit) begin
            if (cur_last && !stuff_pend) begin
              done_n  = 1'b1;
              go_idle = 1'b1;
            end else begin
              state_n = DRIVE;
            end
          end else if (cur_bit && cur_arb) begin
            arb_n   = 1'b1;
            go_idle = 1'b1;
          end else begin
            berr_n  = 1'b1;
            go_idle = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (tx_point) begin
          if (stuff_pend || hold_valid) begin
            do_drive = 1'b1;
            state_n  = SAMPLE;
          end else begin
            under_n = 1'b1;
            go_idle = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    // A stuff bit keeps cur_last so a stuff bit owed after the last bit still ends in tx_done.
    if (do_drive) begin
      if (stuff_pend) begin
        cur_bit_n    = ~last_bit;
        cur_arb_n    = 1'b0;
        tx_n         = ~last_bit;
        run_n        = 3'd1;
        last_bit_n   = ~last_bit;
        stuff_pend_n = 1'b0;
      end else begin
        cur_bit_n    = hold_data;
        cur_arb_n    = hold_arb;
        cur_last_n   = hold_last;
        tx_n         = hold_data;
        hold_valid_n = 1'b0;
        if (hold_stuff) begin
          run_n        = (hold_data == last_bit && run != 3'd0) ? run + 3'd1 : 3'd1;
          last_bit_n   = hold_data;
          stuff_pend_n = (run_n == 3'(STUFF_LEN));
        end else begin
          run_n = 3'd0;
        end
      end
    end

    if (bit_valid && !hold_valid) begin
      hold_valid_n = 1'b1;
      hold_data_n  = bit_data;
      hold_stuff_n = bit_stuff_en;
      hold_arb_n   = bit_arb;
      hold_last_n  = bit_last;
    end

    if (go_idle) begin
      state_n      = IDLE;
      tx_n         = 1'b1;
      run_n        = 3'd0;
      stuff_pend_n = 1'b0;
      last_bit_n   = 1'b1;
    end

    if (go_error_frame) begin
      state_n      = IDLE;
      tx_n         = 1'b1;
      hold_valid_n = 1'b0;
      run_n        = 3'd0;
      stuff_pend_n = 1'b0;
      last_bit_n   = 1'b1;
      done_n       = 1'b0;
      arb_n        = 1'b0;
      berr_n       = 1'b0;
      under_n      = 1'b0;
    end

`ifdef CAN_TX_LOOPBACK_EN
    if (loopback) tx_n = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx           <= 1'b1;
      hold_valid   <= 1'b0;
      hold_data    <= 1'b1;
      hold_stuff   <= 1'b0;
      hold_arb     <= 1'b0;
      hold_last    <= 1'b0;
      cur_bit      <= 1'b1;
      cur_arb      <= 1'b0;
      cur_last     <= 1'b0;
      run          <= 3'd0;
      last_bit     <= 1'b1;
      stuff_pend   <= 1'b0;
      tx_done      <= 1'b0;
      arb_lost     <= 1'b0;
      bit_err      <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state        <= state_n;
      tx           <= tx_n;
      hold_valid   <= hold_valid_n;
      hold_data    <= hold_data_n;
      hold_stuff   <= hold_stuff_n;
      hold_arb     <= hold_arb_n;
      hold_last    <= hold_last_n;
      cur_bit      <= cur_bit_n;
      cur_arb      <= cur_arb_n;
      cur_last     <= cur_last_n;
      run          <= run_n;
      last_bit     <= last_bit_n;
      stuff_pend   <= stuff_pend_n;
      tx_done      <= done_n;
      arb_lost     <= arb_n;
      bit_err      <= berr_n;
      underrun_err <= under_n;
    end
  end

endmodule
